fp_seq: RTL and testbench

FP_SEQ -- requirements
Module: fp_seq

---
 rtl/fp_seq_pkg.sv | 52 +++++
 rtl/fp_strob.sv | 31 +++
 rtl/fp_seq.sv | 172 +++++++++++++++++
 tb/tb_fp_seq.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fp_seq_pkg.sv
// Shared definitions for the FPU sequencer: op codes, phase states,
// phase sub-steps and the op-to-sequence-class mapping.
package fp_seq_pkg;

  typedef enum logic [2:0] {
    OP_AD = 3'd0,
    OP_SD = 3'd1,
    OP_MW = 3'd2,
    OP_DW = 3'd3,
    OP_AF = 3'd4,
    OP_SF = 3'd5,
    OP_MF = 3'd6,
    OP_DF = 3'd7
  } op_e;

  typedef enum logic [3:0] {
    PH_IDLE = 4'd0,
    PH_F2   = 4'd1,
    PH_F4   = 4'd2,
    PH_F5   = 4'd3,
    PH_F6   = 4'd4,
    PH_F7   = 4'd5,
    PH_F8   = 4'd6,
    PH_F9   = 4'd7,
    PH_F10  = 4'd8,
    PH_F13  = 4'd9
  } phase_e;

  typedef enum logic [1:0] {
    ST_S0 = 2'd0,
    ST_S1 = 2'd1,
    ST_S2 = 2'd2
  } step_e;

  // Instructions sharing a phase sequence.
  typedef enum logic [1:0] {
    CL_ADDW = 2'd0,
    CL_ADDF = 2'd1,
    CL_MUL  = 2'd2,
    CL_DIV  = 2'd3
  } op_class_e;

  function automatic op_class_e op_class(input op_e op);
    case (op)
      OP_AD, OP_SD: return CL_ADDW;
      OP_AF, OP_SF: return CL_ADDF;
      OP_MW, OP_MF: return CL_MUL;
      default:      return CL_DIV;
    endcase
  endfunction

endpackage

// File: rtl/fp_strob.sv
// Three-clock phase timer: S0, S1 (strob_fp), S2 (strob2_fp and phase end).
// Restarts at S0 whenever the sequencer is idle.
module fp_strob
  import fp_seq_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic strob_fp,
  output logic strob2_fp,
  output logic phase_end
);

  step_e step_q, step_d;

  always_comb begin
    step_d = step_q;
    if (!en || step_q == ST_S2) step_d = ST_S0;
    else                        step_d = step_e'(step_q + 2'd1);
  end

  always_ff @(posedge clk) begin
    if (rst) step_q <= ST_S0;
    else     step_q <= step_d;
  end

  assign strob_fp  = en && (step_q == ST_S1);
  assign strob2_fp = en && (step_q == ST_S2);
  assign phase_end = strob2_fp;

endmodule

// File: rtl/fp_seq.sv
// FPU instruction phase sequencer: steps through one-hot phases of three
// clocks each, branching on status inputs sampled at the end of each phase.
module fp_seq
  import fp_seq_pkg::*;
#(
  parameter logic [5:0] LOOP_MAX = 6'd48
) (
  input  logic       __clk,
  input  logic       _0_f,
  input  logic       start,
  input  logic [2:0] op,
  input  logic       fic_z,
  input  logic       wt,
  input  logic       wc,
  input  logic       nrm,
  input  logic       ws,
  input  logic       fi,
  output logic       f2,
  output logic       f4,
  output logic       f5,
  output logic       f6,
  output logic       f7,
  output logic       f8,
  output logic       f9,
  output logic       f10,
  output logic       f13,
  output logic       strob_fp,
  output logic       strob2_fp,
  output logic       busy,
  output logic       done,
  output logic       err,
  output logic [3:0] dbg_phase
);

  phase_e    phase_q, phase_d;
  op_e       op_q, op_d;
  logic [5:0] iter_q, iter_d;
  logic      ws_used_q, ws_used_d;
  logic      err_q, err_d;
  logic      done_q, done_d;

  phase_e    nxt_phase;
  logic      rep;
  logic      fault;
  logic      run;
  logic      phase_end;
  op_class_e cls;

  assign run = (phase_q != PH_IDLE);
  assign cls = op_class(op_q);

  fp_strob u_strob (
    .clk       (__clk),
    .rst       (_0_f),
    .en        (run),
    .strob_fp  (strob_fp),
    .strob2_fp (strob2_fp),
    .phase_end (phase_end)
  );

  always_ff @(posedge __clk) begin
    if (_0_f) begin
      phase_q   <= PH_IDLE;
      op_q      <= OP_AD;
      iter_q    <= '0;
      ws_used_q <= 1'b0;
      err_q     <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      op_q      <= op_d;
      iter_q    <= iter_d;
      ws_used_q <= ws_used_d;
      err_q     <= err_d;
      done_q    <= done_d;
    end
  end

  always_comb begin
    phase_d   = phase_q;
    op_d      = op_q;
    iter_d    = iter_q;
    ws_used_d = ws_used_q;
    err_d     = err_q;
    done_d    = 1'b0;
    nxt_phase = PH_IDLE;
    rep       = 1'b0;
    fault     = 1'b0;
    if (phase_q == PH_IDLE) begin
      if (start) begin
        phase_d   = PH_F2;
        op_d      = op_e'(op);
        err_d     = 1'b0;
        ws_used_d = 1'b0;
        iter_d    = '0;
      end
    end else if (phase_end) begin
      case (phase_q)
        PH_F2: nxt_phase = PH_F4;
        PH_F4: begin
          case (cls)
            CL_ADDF: nxt_phase = PH_F5;
            CL_MUL:  nxt_phase = PH_F8;
            default: nxt_phase = PH_F6;
          endcase
        end
        PH_F5: nxt_phase = (wt || wc) ? PH_F13 : PH_F8;
        PH_F6: nxt_phase = (cls == CL_DIV) ? PH_F8 : PH_F7;
        PH_F7: nxt_phase = (cls == CL_ADDW) ? PH_F13 : PH_F10;
        PH_F8: begin
          rep = !fic_z;
          if (cls == CL_ADDF)    nxt_phase = PH_F6;
          else if (op_q == OP_DF) nxt_phase = PH_F9;
          else                   nxt_phase = PH_F10;
        end
        PH_F9: nxt_phase = PH_F10;
        PH_F10: begin
          nxt_phase = PH_F13;
          // Only the first F10 of a divide may send it back for correction.
          if (cls == CL_ADDF) rep = nrm;
          else if (cls == CL_DIV && ws && !ws_used_q) begin
            nxt_phase = PH_F7;
            ws_used_d = 1'b1;
          end
        end
        default: nxt_phase = PH_IDLE;
      endcase
      if (fi) fault = 1'b1;
      else if (rep) begin
        if (iter_q + 6'd1 == LOOP_MAX) fault = 1'b1;
        else                           nxt_phase = phase_q;
      end
      iter_d = (rep && !fault) ? iter_q + 6'd1 : '0;
      if (fault || nxt_phase == PH_IDLE) begin
        phase_d = PH_IDLE;
        done_d  = 1'b1;
        err_d   = err_q | fault;
      end else begin
        phase_d = nxt_phase;
      end
    end
  end

  always_comb begin
    f2  = 1'b0;
    f4  = 1'b0;
    f5  = 1'b0;
    f6  = 1'b0;
    f7  = 1'b0;
    f8  = 1'b0;
    f9  = 1'b0;
    f10 = 1'b0;
    f13 = 1'b0;
    case (phase_q)
      PH_F2:   f2  = 1'b1;
      PH_F4:   f4  = 1'b1;
      PH_F5:   f5  = 1'b1;
      PH_F6:   f6  = 1'b1;
      PH_F7:   f7  = 1'b1;
      PH_F8:   f8  = 1'b1;
      PH_F9:   f9  = 1'b1;
      PH_F10:  f10 = 1'b1;
      PH_F13:  f13 = 1'b1;
      default: ;
    endcase
    busy      = run;
    done      = done_q;
    err       = err_q;
    dbg_phase = phase_q;
  end

endmodule

// File: tb/tb_fp_seq.sv
// Bench for fp_seq: a procedural model walks each instruction's phase flow
// and publishes per-cycle expectations; a negedge process compares the DUT.
module tb_fp_seq;

  localparam int LOOP_MAX = 48;

  logic       __clk = 1'b0;
  logic       _0_f, start;
  logic [2:0] op;
  logic       fic_z, wt, wc, nrm, ws, fi;
  logic       f2, f4, f5, f6, f7, f8, f9, f10, f13;
  logic       strob_fp, strob2_fp, busy, done, err;
  logic [3:0] dbg_phase;

  always #5 __clk = ~__clk;

  fp_seq #(.LOOP_MAX(6'd48)) dut (
    .__clk(__clk), ._0_f(_0_f), .start(start), .op(op),
    .fic_z(fic_z), .wt(wt), .wc(wc), .nrm(nrm), .ws(ws), .fi(fi),
    .f2(f2), .f4(f4), .f5(f5), .f6(f6), .f7(f7), .f8(f8), .f9(f9),
    .f10(f10), .f13(f13), .strob_fp(strob_fp), .strob2_fp(strob2_fp),
    .busy(busy), .done(done), .err(err), .dbg_phase(dbg_phase)
  );

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  always @(posedge __clk) cyc <= cyc + 1;

  // Expected outputs for the current cycle.
  int exp_ph = 0;
  bit exp_s1, exp_s2, exp_busy, exp_done, exp_err;
  bit chk_en = 1'b0;
  int dut_done_cyc = -1;

  // Model state and stimulus knobs.
  bit    fault, aborted, model_err;
  string trace_s;
  int    n_f8, n_f10, cur_it, start_cyc;
  int    fic_n, nrm_n, ws_mode, wtwc_mode, fi_ph, rst_ph;
  bit    s_fic, s_nrm, s_ws, s_wt, s_wc, s_fi;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_err++;
      $display("FAIL %s act=%0h exp=%0h cyc=%0d", name, act, expv, cyc);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string expv);
    n_cmp++;
    if (act != expv) begin
      n_err++;
      $display("FAIL %s act=%s exp=%s", name, act, expv);
    end
  endtask

  function automatic logic [8:0] onehot(input int ph);
    case (ph)
      2:       return 9'b1_0000_0000;
      4:       return 9'b0_1000_0000;
      5:       return 9'b0_0100_0000;
      6:       return 9'b0_0010_0000;
      7:       return 9'b0_0001_0000;
      8:       return 9'b0_0000_1000;
      9:       return 9'b0_0000_0100;
      10:      return 9'b0_0000_0010;
      13:      return 9'b0_0000_0001;
      default: return 9'b0;
    endcase
  endfunction

  always @(negedge __clk) begin
    logic [8:0] pv;
    if (chk_en) begin
      pv = {f2, f4, f5, f6, f7, f8, f9, f10, f13};
      chk("phase", 32'(pv), 32'(onehot(exp_ph)));
      chk("strob_fp", 32'(strob_fp), 32'(exp_s1));
      chk("strob2_fp", 32'(strob2_fp), 32'(exp_s2));
      chk("busy", 32'(busy), 32'(exp_busy));
      chk("done", 32'(done), 32'(exp_done));
      chk("err", 32'(err), 32'(exp_err));
      chk("one_hot", 32'($countones(pv) <= 1), 32'd1);
      chk("strobe_excl", 32'(strob_fp & strob2_fp), 32'd0);
      if (done === 1'b1) dut_done_cyc = cyc;
    end
  end

  task automatic tick();
    @(posedge __clk);
    #1;
  endtask

  task automatic set_exp(input int ph, input bit s1, input bit s2, input bit b,
                         input bit d, input bit e);
    exp_ph = ph; exp_s1 = s1; exp_s2 = s2;
    exp_busy = b; exp_done = d; exp_err = e;
  endtask

  task automatic drive_rand();
    fic_z = 1'($urandom_range(0, 1));
    wt    = 1'($urandom_range(0, 1));
    wc    = 1'($urandom_range(0, 1));
    nrm   = 1'($urandom_range(0, 1));
    ws    = 1'($urandom_range(0, 1));
    fi    = 1'($urandom_range(0, 1));
    op    = 3'($urandom_range(0, 7));
    start = ($urandom_range(0, 3) == 0);
  endtask

  task automatic drive_inputs(input int code, input int s);
    drive_rand();
    if (s == 2) begin
      fic_z = (fic_n < 0) ? ($urandom_range(0, 9) < 4) : (fic_n > 0 && cur_it + 1 >= fic_n);
      nrm   = (nrm_n < 0) ? ($urandom_range(0, 9) < 4) : (cur_it + 1 < nrm_n);
      ws    = (ws_mode < 0) ? 1'($urandom_range(0, 1)) : ws_mode[0];
      if (wtwc_mode < 0) begin
        wt = ($urandom_range(0, 3) == 0);
        wc = ($urandom_range(0, 3) == 0);
      end else begin
        wt = wtwc_mode[0];
        wc = wtwc_mode[0];
      end
      fi = (fi_ph < 0) ? ($urandom_range(0, 29) == 0) : (fi_ph == code);
      s_fic = fic_z; s_nrm = nrm; s_ws = ws; s_wt = wt; s_wc = wc; s_fi = fi;
    end
    if (rst_ph == code && s == 1 && !aborted) begin
      _0_f = 1'b1;
      start = 1'b1;
      aborted = 1'b1;
    end
  endtask

  function automatic bit go();
    return !fault && !aborted;
  endfunction

  task automatic ph(input int code);
    trace_s = {trace_s, $sformatf("%0d,", code)};
    if (code == 8)  n_f8++;
    if (code == 10) n_f10++;
    for (int s = 0; s < 3; s++) begin
      set_exp(code, s == 1, s == 2, 1'b1, 1'b0, 1'b0);
      drive_inputs(code, s);
      tick();
      if (aborted) begin
        set_exp(0, 0, 0, 0, 0, 0);
        model_err = 1'b0;
        return;
      end
    end
    if (s_fi) fault = 1'b1;
  endtask

  task automatic loop_ph(input int code);
    bit cont;
    if (!go()) return;
    cur_it = 0;
    while (1) begin
      ph(code);
      if (!go()) break;
      cont = (code == 8) ? !s_fic : s_nrm;
      if (!cont) break;
      cur_it++;
      if (cur_it == LOOP_MAX) begin
        fault = 1'b1;
        break;
      end
    end
    cur_it = 0;
  endtask

  task automatic run_instr(input int opc);
    fault = 1'b0; aborted = 1'b0; trace_s = "";
    n_f8 = 0; n_f10 = 0; cur_it = 0;
    drive_rand();
    start = 1'b1;
    op = 3'(opc);
    _0_f = 1'b0;
    tick();
    start_cyc = cyc;
    if (opc == 0 || opc == 1) begin
      ph(2); if (go()) ph(4); if (go()) ph(6); if (go()) ph(7); if (go()) ph(13);
    end else if (opc == 4 || opc == 5) begin
      ph(2); if (go()) ph(4); if (go()) ph(5);
      if (go()) begin
        if (s_wt || s_wc) ph(13);
        else begin
          loop_ph(8);
          if (go()) ph(6);
          if (go()) ph(7);
          loop_ph(10);
          if (go()) ph(13);
        end
      end
    end else if (opc == 2 || opc == 6) begin
      ph(2); if (go()) ph(4); loop_ph(8); if (go()) ph(10); if (go()) ph(13);
    end else begin
      ph(2); if (go()) ph(4); if (go()) ph(6); loop_ph(8);
      if (go() && opc == 7) ph(9);
      if (go()) ph(10);
      if (go() && s_ws) begin
        ph(7);
        if (go()) ph(10);
      end
      if (go()) ph(13);
    end
    if (aborted) begin
      drive_rand();
      start = 1'b0;
      _0_f = 1'b0;
      tick();
    end else begin
      set_exp(0, 0, 0, 0, 1, fault);
      drive_rand();
      start = 1'b0;
      tick();
      model_err = fault;
      set_exp(0, 0, 0, 0, 0, model_err);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      drive_rand();
      start = 1'b0;
      tick();
    end
  endtask

  task automatic knobs(input int fn, input int nn, input int wm, input int tm,
                       input int fp, input int rp);
    fic_n = fn; nrm_n = nn; ws_mode = wm; wtwc_mode = tm; fi_ph = fp; rst_ph = rp;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    _0_f = 1'b1; start = 1'b0; op = '0;
    fic_z = 0; wt = 0; wc = 0; nrm = 0; ws = 0; fi = 0;
    model_err = 1'b0;
    set_exp(0, 0, 0, 0, 0, 0);
    knobs(-1, -1, -1, -1, 0, 0);
    tick();
    chk_en = 1'b1;
    start = 1'b1;
    tick();
    _0_f = 1'b0;
    start = 1'b0;
    tick();

    // ad: fixed five-phase flow, 15 clocks from the start edge to done.
    knobs(-1, -1, -1, -1, 0, 0);
    run_instr(0);
    chk("lat_ad", 32'(dut_done_cyc - start_cyc), 32'd15);
    chk_str("trace_ad", trace_s, "2,4,6,7,13,");
    idle(2);

    // af: three F8 passes, single F10.
    knobs(3, 0, -1, 0, 0, 0);
    run_instr(4);
    chk_str("trace_af", trace_s, "2,4,5,8,8,8,6,7,10,13,");
    idle(1);

    // df with correction: ws only honoured at the first F10.
    knobs(1, -1, 1, -1, 0, 0);
    run_instr(7);
    chk_str("trace_df_ws", trace_s, "2,4,6,8,9,10,7,10,13,");
    idle(1);

    // mw loop never terminates: loop fault after 48 passes.
    knobs(0, -1, -1, -1, 0, 0);
    run_instr(2);
    chk("loop_f8_count", 32'(n_f8), 32'd48);
    chk("loop_no_f10", 32'(n_f10), 32'd0);
    chk("loop_err_dut", 32'(err), 32'd1);
    idle(1);

    // dw with fault request at the end of F4, then a clean restart.
    knobs(-1, -1, -1, -1, 4, 0);
    run_instr(3);
    chk_str("trace_fi", trace_s, "2,4,");
    chk("fi_err_dut", 32'(err), 32'd1);
    knobs(-1, -1, -1, -1, 0, 0);
    run_instr(1);
    chk("restart_err_dut", 32'(err), 32'd0);
    idle(1);

    // Reset in the middle of F8 S1 with a coincident start.
    knobs(0, -1, -1, -1, 0, 8);
    run_instr(6);
    chk_str("trace_rst", trace_s, "2,4,8,");
    chk("rst_busy_dut", 32'(busy), 32'd0);
    idle(2);
    knobs(-1, -1, -1, -1, 0, 0);
    run_instr(5);
    idle(1);

    for (int i = 0; i < 40; i++) begin
      knobs(-1, -1, -1, -1, -1, ($urandom_range(0, 9) == 0) ? 8 : 0);
      run_instr(int'($urandom_range(0, 7)));
      idle(int'($urandom_range(0, 2)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
